// File: rtl/me_mb_scheduler_if.sv
// Control/handshake bundle between the ME macroblock scheduler and the datapath blocks it sequences.
interface me_mb_scheduler_if #(
  parameter int CUR_WORDS = 64,
  parameter int REF_WORDS = 128
);
  logic                         frame_start;
  logic                         cur_req, cur_gnt;
  logic [$clog2(CUR_WORDS)-1:0] cur_addr;
  logic                         ref_req, ref_gnt;
  logic [$clog2(REF_WORDS)-1:0] ref_addr;
  logic                         core_start, core_done;
  logic                         res_valid, res_ready;
  logic [7:0]                   mb_x, mb_y;
  logic                         res_err, busy, frame_done;

  modport master (
    input  frame_start, cur_gnt, ref_gnt, core_done, res_ready,
    output cur_req, cur_addr, ref_req, ref_addr, core_start,
           res_valid, mb_x, mb_y, res_err, busy, frame_done
  );

  modport slave (
    output frame_start, cur_gnt, ref_gnt, core_done, res_ready,
    input  cur_req, cur_addr, ref_req, ref_addr, core_start,
           res_valid, mb_x, mb_y, res_err, busy, frame_done
  );
endinterface

// File: rtl/me_mb_scheduler.sv
// Per-macroblock sequencer for motion estimation: current block, search window, SAD run, result emit.
// Define ME_TIMEOUT_EN to add a watchdog that aborts a stuck WAIT with res_err.
module me_mb_scheduler #(
  parameter int MB_COLS     = 240,
  parameter int MB_ROWS     = 135,
  parameter int CUR_WORDS   = 64,
  parameter int REF_WORDS   = 128,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic               clk,
  input logic               rst,
  me_mb_scheduler_if.master mb
);
  localparam int CAW = $clog2(CUR_WORDS);
  localparam int RAW = $clog2(REF_WORDS);
  localparam int WW  = (CAW > RAW) ? CAW : RAW;

  typedef enum logic [2:0] {IDLE, LOAD_CUR, LOAD_REF, RUN, WAIT, EMIT} state_t;

  state_t        state, state_n;
  logic [WW-1:0] wcnt;
  logic [7:0]    x, y;
  logic          fdone;
  logic          cur_req, ref_req, core_start, res_valid;
  logic          cur_last, ref_last, hs, last_mb, timeout;

  assign cur_last = (state == LOAD_CUR) && mb.cur_gnt && (wcnt == WW'(CUR_WORDS - 1));
  assign ref_last = (state == LOAD_REF) && mb.ref_gnt && (wcnt == WW'(REF_WORDS - 1));
  assign hs       = (state == EMIT) && mb.res_ready;
  assign last_mb  = (x == 8'(MB_COLS - 1)) && (y == 8'(MB_ROWS - 1));

`ifdef ME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wdog;
  logic          err;

  // A strobe on the final watchdog cycle still counts as a real result.
  assign timeout = (state == WAIT) && !mb.core_done && (wdog == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      if (state == RUN)       wdog <= '0;
      else if (state == WAIT) wdog <= wdog + TW'(1);
      if (timeout) err <= 1'b1;
      else if (hs) err <= 1'b0;
    end
  end

  assign mb.res_err = err;
`else
  assign timeout    = 1'b0;
  assign mb.res_err = 1'b0;
  // TIMEOUT_CYC only sizes the watchdog; nothing to build without it.
  if (TIMEOUT_CYC < 1) begin : g_no_watchdog
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cur_req    = 1'b0;
    ref_req    = 1'b0;
    core_start = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE:     if (mb.frame_start) state_n = LOAD_CUR;
      LOAD_CUR: begin
        cur_req = 1'b1;
        if (cur_last) state_n = LOAD_REF;
      end
      LOAD_REF: begin
        ref_req = 1'b1;
        if (ref_last) state_n = RUN;
      end
      RUN: begin
        core_start = 1'b1;
        state_n    = WAIT;
      end
      WAIT:     if (mb.core_done || timeout) state_n = EMIT;
      EMIT: begin
        res_valid = 1'b1;
        if (hs) state_n = last_mb ? IDLE : LOAD_CUR;
      end
      default:  state_n = IDLE;
    endcase
  end

  // One word counter serves both fetch phases; it is zero again on each phase exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt  <= '0;
      x     <= '0;
      y     <= '0;
      fdone <= 1'b0;
    end else begin
      fdone <= hs && last_mb;
      if (state == LOAD_CUR && mb.cur_gnt)      wcnt <= cur_last ? '0 : wcnt + WW'(1);
      else if (state == LOAD_REF && mb.ref_gnt) wcnt <= ref_last ? '0 : wcnt + WW'(1);
      if (state == IDLE && mb.frame_start) begin
        x <= '0;
        y <= '0;
      end else if (hs) begin
        if (last_mb) begin
          x <= '0;
          y <= '0;
        end else if (x == 8'(MB_COLS - 1)) begin
          x <= '0;
          y <= y + 8'd1;
        end else begin
          x <= x + 8'd1;
        end
      end
    end
  end

  assign mb.cur_req    = cur_req;
  assign mb.cur_addr   = cur_req ? wcnt[CAW-1:0] : '0;
  assign mb.ref_req    = ref_req;
  assign mb.ref_addr   = ref_req ? wcnt[RAW-1:0] : '0;
  assign mb.core_start = core_start;
  assign mb.res_valid  = res_valid;
  assign mb.mb_x       = x;
  assign mb.mb_y       = y;
  assign mb.busy       = (state != IDLE);
  assign mb.frame_done = fdone;
endmodule

// File: tb/tb_me_mb_scheduler.sv
// Bench for me_mb_scheduler: directed scenarios plus random traffic against a progress-count model.
module tb_me_mb_scheduler;
  localparam int COLS = 3, ROWS = 2, CW = 4, RW = 8, TO = 16;
  localparam int NMB  = COLS * ROWS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0, fails = 0;

  me_mb_scheduler_if #(.CUR_WORDS(CW), .REF_WORDS(RW)) mb ();

  me_mb_scheduler #(
    .MB_COLS(COLS), .MB_ROWS(ROWS), .CUR_WORDS(CW), .REF_WORDS(RW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mb (mb)
  );

  always #5 clk = ~clk;

  // SAD core stand-in: core_done is high in the cycle core_lat cycles after core_start.
  logic auto_done = 1'b0, inj_done = 1'b0, core_en = 1'b1;
  int   core_lat = 3, pend = 0;
  assign mb.core_done = auto_done | inj_done;

  always @(negedge clk) begin
    auto_done = 1'b0;
    if (!rst) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) auto_done = 1'b1;
      end
      if (mb.core_start && core_en) pend = core_lat;
    end
  end

  logic [27:0] obs, ev;
  assign obs = {mb.cur_req, mb.cur_addr, mb.ref_req, mb.ref_addr, mb.core_start, mb.res_valid,
                mb.mb_x, mb.mb_y, mb.res_err, mb.busy, mb.frame_done};

  // Reference model: words granted so far, core fired/finished, MB index within the frame.
  bit m_act, m_fired, m_done, m_err, m_fd;
  int m_idx, m_nc, m_nr, m_wt;

  task automatic model_clear_mb();
    m_nc = 0; m_nr = 0; m_wt = 0;
    m_fired = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_reset();
    m_act = 0; m_idx = 0; m_fd = 0;
    model_clear_mb();
  endtask

  task automatic model_step(input bit fs, input bit cg, input bit rg, input bit cd, input bit rr);
    bit fd_next;
    fd_next = 0;
    if (!m_act) begin
      if (fs) begin m_act = 1; m_idx = 0; model_clear_mb(); end
    end else if (m_nc < CW) begin
      if (cg) m_nc++;
    end else if (m_nr < RW) begin
      if (rg) m_nr++;
    end else if (!m_fired) begin
      m_fired = 1;
    end else if (!m_done) begin
      if (cd) m_done = 1;
`ifdef ME_TIMEOUT_EN
      else begin
        m_wt++;
        if (m_wt == TO) begin m_done = 1; m_err = 1; end
      end
`endif
    end else if (rr) begin
      m_idx++;
      model_clear_mb();
      if (m_idx == NMB) begin m_act = 0; m_idx = 0; fd_next = 1; end
    end
    m_fd = fd_next;
  endtask

  function automatic logic [27:0] exp_vec();
    logic cr, rq, cs, rv;
    logic [1:0] ca;
    logic [2:0] ra;
    logic [7:0] ex, ey;
    cr = m_act && (m_nc < CW);
    ca = cr ? 2'(m_nc) : 2'd0;
    rq = m_act && (m_nc == CW) && (m_nr < RW);
    ra = rq ? 3'(m_nr) : 3'd0;
    cs = m_act && (m_nr == RW) && !m_fired;
    rv = m_act && m_done;
    ex = m_act ? 8'(m_idx % COLS) : 8'd0;
    ey = m_act ? 8'(m_idx / COLS) : 8'd0;
    return {cr, ca, rq, ra, cs, rv, ex, ey, rv && m_err, m_act, m_fd};
  endfunction

  // Drive one cycle of inputs, advance the model, land just after the next falling edge.
  task automatic step(input bit fs, input bit cg, input bit rg, input bit inj, input bit rr);
    mb.frame_start = fs; mb.cur_gnt = cg; mb.ref_gnt = rg; mb.res_ready = rr; inj_done = inj;
    model_step(fs, cg, rg, auto_done | inj, rr);
    @(negedge clk); #1;
  endtask

  task automatic apply_reset();
    mb.frame_start = 0; mb.cur_gnt = 0; mb.ref_gnt = 0; mb.res_ready = 0; inj_done = 0;
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (obs !== 28'd0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    rst = 1'b1;
    step(0, 1, 1, 0, 1);
    ev = exp_vec();
    tests++;
    if (obs !== ev) begin fails++; $display("FAIL idle_ignores_gnt: got %h expected %h", obs, ev); end
  endtask

  task automatic test_full_frame();
    int hs_cyc[$], hs_x[$], hs_y[$];
    int fd_cnt, fd_cyc;
    bit fin, busy_bad;
    fd_cnt = 0; fd_cyc = -1; fin = 0; busy_bad = 0;
    core_lat = 3;
    step(1, 1, 1, 0, 1);
    for (int c = 1; c < 200 && !fin; c++) begin
      ev = exp_vec();
      tests++;
      if (obs !== ev) begin fails++; $display("FAIL full_frame_cycle %0d: got %h expected %h", c, obs, ev); end
      if (mb.res_valid) begin hs_cyc.push_back(c); hs_x.push_back(int'(mb.mb_x)); hs_y.push_back(int'(mb.mb_y)); end
      if (mb.frame_done) begin fd_cnt++; fd_cyc = c; fin = 1; if (mb.busy) busy_bad = 1; end
      step(0, 1, 1, 0, 1);
    end
    for (int i = 0; i < 4; i++) begin
      if (mb.frame_done) fd_cnt++;
      step(0, 1, 1, 0, 1);
    end
    tests++;
    if (hs_cyc.size() != NMB) begin fails++; $display("FAIL full_frame_results: got %0d expected %0d", hs_cyc.size(), NMB); end
    for (int i = 0; i < hs_cyc.size(); i++) begin
      tests++;
      if (hs_x[i] != i % COLS || hs_y[i] != i / COLS) begin
        fails++; $display("FAIL full_frame_coord %0d: got (%0d,%0d) expected (%0d,%0d)", i, hs_x[i], hs_y[i], i % COLS, i / COLS);
      end
      tests++;
      if (hs_cyc[i] != 17 * (i + 1)) begin
        fails++; $display("FAIL full_frame_timing %0d: got cycle %0d expected %0d", i, hs_cyc[i], 17 * (i + 1));
      end
    end
    tests++;
    if (fd_cnt != 1 || fd_cyc != 17 * NMB + 1) begin
      fails++; $display("FAIL frame_done_pulse: got count %0d at %0d expected 1 at %0d", fd_cnt, fd_cyc, 17 * NMB + 1);
    end
    tests++;
    if (busy_bad) begin fails++; $display("FAIL busy_with_frame_done: got 1 expected 0"); end
  endtask

  task automatic test_gnt_toggle();
    int addrs[$];
    int exp_a[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    bit ref_early;
    ref_early = 0;
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      ev = exp_vec();
      tests++;
      if (obs !== ev) begin fails++; $display("FAIL toggle_cycle %0d: got %h expected %h", i, obs, ev); end
      if (mb.ref_req) ref_early = 1;
      addrs.push_back(int'(mb.cur_addr));
      step(0, (i % 2) == 1, 1, 0, 1);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (addrs[i] != exp_a[i]) begin fails++; $display("FAIL toggle_addr %0d: got %0d expected %0d", i, addrs[i], exp_a[i]); end
    end
    tests++;
    if (ref_early || mb.ref_req !== 1'b1 || mb.cur_req !== 1'b0 || mb.ref_addr !== 3'd0) begin
      fails++; $display("FAIL toggle_ref_start: got early=%0d ref_req=%b cur_req=%b expected 0,1,0", ref_early, mb.ref_req, mb.cur_req);
    end
    apply_reset();
  endtask

  task automatic test_stall();
    int c;
    c = 1;
    step(1, 1, 1, 0, 0);
    while (!mb.res_valid && c < 60) begin
      ev = exp_vec();
      tests++;
      if (obs !== ev) begin fails++; $display("FAIL stall_cycle %0d: got %h expected %h", c, obs, ev); end
      step(0, 1, 1, 0, 0);
      c++;
    end
    tests++;
    if (!mb.res_valid) begin fails++; $display("FAIL stall_reach_emit: got res_valid=0 expected 1"); end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if ({mb.res_valid, mb.cur_req, mb.mb_x, mb.mb_y} !== {1'b1, 1'b0, 16'd0}) begin
        fails++; $display("FAIL stall_hold %0d: got v=%b req=%b (%0d,%0d) expected v=1 req=0 (0,0)", i, mb.res_valid, mb.cur_req, mb.mb_x, mb.mb_y);
      end
      step(0, 1, 1, 0, 0);
    end
    step(0, 0, 1, 0, 1);
    tests++;
    if ({mb.res_valid, mb.cur_req, mb.cur_addr, mb.mb_x, mb.mb_y} !== {1'b0, 1'b1, 2'd0, 8'd1, 8'd0}) begin
      fails++; $display("FAIL stall_release: got v=%b req=%b (%0d,%0d) expected v=0 req=1 (1,0)", mb.res_valid, mb.cur_req, mb.mb_x, mb.mb_y);
    end
    apply_reset();
  endtask

  task automatic test_ignored();
    int c;
    c = 1;
    core_lat = 3;
    step(1, 1, 1, 0, 1);
    while (!mb.res_valid && c < 60) begin
      ev = exp_vec();
      tests++;
      if (obs !== ev) begin fails++; $display("FAIL ignored_cycle %0d: got %h expected %h", c, obs, ev); end
      // frame_start mid-fetch; core_done during the current-block fetch and in the RUN cycle
      step(c == 7, 1, 1, (c == 2) || (c == 13), 1);
      c++;
    end
    tests++;
    if (c != 17 || mb.mb_x !== 8'd0 || mb.mb_y !== 8'd0) begin
      fails++; $display("FAIL ignored_first_result: got cycle %0d (%0d,%0d) expected cycle 17 (0,0)", c, mb.mb_x, mb.mb_y);
    end
    step(0, 1, 1, 0, 1);
    tests++;
    if (mb.cur_req !== 1'b1 || mb.mb_x !== 8'd1) begin
      fails++; $display("FAIL ignored_next_mb: got req=%b x=%0d expected req=1 x=1", mb.cur_req, mb.mb_x);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    int c;
    c = 1;
    core_lat = 3;
    step(1, 1, 1, 0, 1);
    // MB (1,0) fires at cycle 30, so cycle 31 is its WAIT
    while (c < 31) begin
      ev = exp_vec();
      tests++;
      if (obs !== ev) begin fails++; $display("FAIL reset_mid_cycle %0d: got %h expected %h", c, obs, ev); end
      step(0, 1, 1, 0, 1);
      c++;
    end
    ev = exp_vec();
    tests++;
    if (obs !== ev || mb.mb_x !== 8'd1) begin fails++; $display("FAIL reset_mid_wait: got %h expected %h", obs, ev); end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (obs !== 28'd0) begin fails++; $display("FAIL reset_mid_async: got %h expected 0", obs); end
    model_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    step(1, 1, 1, 0, 1);
    c = 1;
    while (!mb.res_valid && c < 60) begin
      ev = exp_vec();
      tests++;
      if (obs !== ev) begin fails++; $display("FAIL restart_cycle %0d: got %h expected %h", c, obs, ev); end
      step(0, 1, 1, 0, 1);
      c++;
    end
    tests++;
    if (c != 17 || mb.mb_x !== 8'd0 || mb.mb_y !== 8'd0) begin
      fails++; $display("FAIL restart_first_result: got cycle %0d (%0d,%0d) expected cycle 17 (0,0)", c, mb.mb_x, mb.mb_y);
    end
    apply_reset();
  endtask

  task automatic test_timeout();
    int c;
    c = 1;
    core_en = 1'b0;
    core_lat = 3;
    step(1, 1, 1, 0, 0);
`ifdef ME_TIMEOUT_EN
    while (!mb.res_valid && c < 80) begin
      ev = exp_vec();
      tests++;
      if (obs !== ev) begin fails++; $display("FAIL timeout_cycle %0d: got %h expected %h", c, obs, ev); end
      step(0, 1, 1, 0, 0);
      c++;
    end
    tests++;
    if (c != 30 || mb.res_err !== 1'b1) begin
      fails++; $display("FAIL timeout_emit: got cycle %0d err=%b expected cycle 30 err=1", c, mb.res_err);
    end
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    tests++;
    if (mb.res_valid !== 1'b1 || mb.res_err !== 1'b1 || mb.mb_x !== 8'd0) begin
      fails++; $display("FAIL timeout_late_done: got v=%b err=%b x=%0d expected v=1 err=1 x=0", mb.res_valid, mb.res_err, mb.mb_x);
    end
    core_en = 1'b1;
    step(0, 1, 1, 0, 1);
    c = 1;
    while (!mb.res_valid && c < 60) begin
      ev = exp_vec();
      tests++;
      if (obs !== ev) begin fails++; $display("FAIL timeout_next_cycle %0d: got %h expected %h", c, obs, ev); end
      step(0, 1, 1, 0, 1);
      c++;
    end
    tests++;
    if (c != 17 || mb.res_err !== 1'b0 || mb.mb_x !== 8'd1) begin
      fails++; $display("FAIL timeout_next_mb: got cycle %0d err=%b x=%0d expected cycle 17 err=0 x=1", c, mb.res_err, mb.mb_x);
    end
`else
    for (int i = 0; i < 60; i++) begin
      ev = exp_vec();
      tests++;
      if (obs !== ev) begin fails++; $display("FAIL no_timeout_cycle %0d: got %h expected %h", i, obs, ev); end
      step(0, 1, 1, 0, 1);
    end
    tests++;
    if (mb.res_valid !== 1'b0 || mb.busy !== 1'b1 || mb.res_err !== 1'b0) begin
      fails++; $display("FAIL no_timeout_wait: got v=%b busy=%b err=%b expected 0,1,0", mb.res_valid, mb.busy, mb.res_err);
    end
`endif
    core_en = 1'b1;
    apply_reset();
  endtask

  task automatic test_random();
    int c;
    for (int f = 0; f < 3; f++) begin
      core_lat = int'($urandom_range(1, 6));
      step(1, ($urandom % 2) == 1, 1, 0, ($urandom % 2) == 1);
      c = 0;
      while (!mb.frame_done && c < 3000) begin
        ev = exp_vec();
        tests++;
        if (obs !== ev) begin fails++; $display("FAIL random_f%0d_cycle %0d: got %h expected %h", f, c, obs, ev); end
        step(($urandom % 8) == 0, ($urandom % 2) == 1, ($urandom % 3) != 0,
             ($urandom % 10) == 0, ($urandom % 3) != 0);
        c++;
      end
      ev = exp_vec();
      tests++;
      if (!mb.frame_done || obs !== ev) begin
        fails++; $display("FAIL random_f%0d_end: got %h expected %h", f, obs, ev);
      end
      step(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    mb.frame_start = 0; mb.cur_gnt = 0; mb.ref_gnt = 0; mb.res_ready = 0;
    model_reset();
    test_reset();
    test_full_frame();
    test_gnt_toggle();
    test_stall();
    test_ignored();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
